regfile_port_sequencer: RTL and testbench
=========================================

REGFILE_PORT_SEQUENCER -- requirements
Module: regfile_port_sequencer

Interface
REQ-001 SHALL have parameter REGS, default 32, number of registers addressed; addresses are 5 bits and wrap modulo 32.
REQ-002 SHALL have parameter WIDTH, default 64, data word width.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 start  input  1  single-cycle request to begin a transfer; accepted only in IDLE.
REQ-006 mode  input  1  sampled with start: 0 = load (stream into register file), 1 = dump (register file onto stream).
REQ-007 base  input  5  first register address, sampled with start.
REQ-008 count  input  6  number of registers to transfer, sampled with start.
REQ-009 in_data  input  64  load stream data.
REQ-010 in_valid  input  1  load stream valid.
REQ-011 in_ready  output  1  load stream ready.
REQ-012 out_data  output  64  dump stream data, registered.
REQ-013 out_valid  output  1  dump stream valid, registered.
REQ-014 out_ready  input  1  dump stream ready.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  single-cycle pulse at the end of every accepted transfer.
REQ-017 peek_addr  input  5  passed directly to SB.
REQ-018 peek_data  output  64  passed directly from B.
REQ-019 SA, SB, DA  output  5 each  register-file read-A, read-B and write addresses.
REQ-020 D  output  64  register-file write data.
REQ-021 W  output  1  register-file write enable; the register file writes on the rising edge.
REQ-022 A, B  input  64 each  register-file read data; combinational from SA and SB.

Function
REQ-023 The FSM SHALL have four states: IDLE, LOAD, DUMP, DONE.
REQ-024 In IDLE, start SHALL latch base into ptr and the effective count into rem, then go to LOAD (mode 0) or DUMP (mode 1).
REQ-025 The effective count SHALL be computed as follows: count 0 goes directly to DONE with no transfers; count 33..63 saturates to 32.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 LOAD: in_ready SHALL be 1.
REQ-028 LOAD, while in_valid is high: W=1, DA=ptr and D=in_data, all combinational, so the word is written at that same edge; ptr increments and rem decrements.
REQ-029 LOAD: the beat with rem==1 SHALL be the last beat; the FSM then goes to DONE.
REQ-030 W SHALL be 0 outside LOAD handshake cycles.
REQ-031 In every state other than LOAD, in_ready SHALL be 0 and DA and D SHALL be 0.
REQ-032 DUMP: SA SHALL equal ptr at all times; one cycle after entry, out_data is loaded with A, out_valid is set, and ptr increments.
REQ-033 DUMP: while out_valid is high and out_ready is low, out_data and out_valid SHALL hold stable.
REQ-034 DUMP: on out_valid && out_ready with rem>1, out_data SHALL reload from A (at SA=ptr) in the same edge, ptr increments and rem decrements, giving one word per cycle at full throughput.
REQ-035 DUMP: on out_valid && out_ready with rem==1, the FSM SHALL clear out_valid and go to DONE.
REQ-036 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-037 Latency SHALL be: start to first out_valid = 2 cycles; start to in_ready = 1 cycle.
REQ-038 A transfer crossing address 31 SHALL wrap to 0; for example, base 30 with count 4 transfers addresses 30, 31, 0, 1.
REQ-039 peek_addr to SB and B to peek_data SHALL be combinational and operate in all states, including during a transfer.

Reset
REQ-040 While reset=0 at an edge, the block SHALL set state=IDLE, ptr=0, rem=0, out_data=0, out_valid=0, done=0.
REQ-041 Reset SHALL take effect at the next edge even mid-transfer; W, in_ready and busy are 0 in the cycle following reset.
REQ-042 Registers already written before reset SHALL be retained; there is no rollback of partial loads.

Verification
REQ-043 Load: base=0, count=32, in_valid held high, data k+0xA5A5_0000_0000_0000 -> registers 0..31 written with their beat value; done pulses in cycle 33 after start.
REQ-044 Dump full throughput: preload R5..R8, base=5, count=4, out_ready=1 -> out_data carries R5..R8 on 4 consecutive cycles; the first out_valid appears 2 cycles after start.
REQ-045 Dump backpressure and wrap: base=30, count=3, out_ready toggling 1,0,0,1,... -> the sequence R30, R31, R0 is emitted, each held stable while out_ready=0.
REQ-046 Edge counts: count=0 -> done 1 cycle after start with no W and no out_valid; count=40 -> exactly 32 beats.
REQ-047 Reset mid-load after 3 beats of 8 -> 3 registers updated, rest unchanged; busy=0; a new start is accepted next cycle.
REQ-048 start asserted during a dump -> ignored; peek_addr=7 -> peek_data equals R7 in every cycle.

Source files
------------

// File: rtl/regfile_port_sequencer.sv
// regfile_port_sequencer
//   Moves a run of consecutive register-file entries to or from a
//   valid/ready stream. A load writes stream beats into the register file
//   through the write port (DA/D/W). A dump reads the register file through
//   read port A (SA/A) onto a registered output stream. Read port B (SB/B) is
//   passed straight through as an always-available peek path.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-low reset
//   start, mode           transfer request (IDLE only); 0 = load, 1 = dump
//   base, count           first register address, number of registers
//   in_data/in_valid/in_ready     load stream
//   out_data/out_valid/out_ready  dump stream (data/valid registered)
//   busy, done            not-IDLE flag, end-of-transfer pulse
//   peek_addr, peek_data  combinational peek through read port B
//   SA, SB, DA, D, W      register-file read/write addresses, write data/enable
//   A, B                  register-file read data (combinational from SA/SB)
module regfile_port_sequencer #(
  parameter int REGS  = 32,
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [4:0]       base,
  input  logic [5:0]       count,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  input  logic [4:0]       peek_addr,
  output logic [WIDTH-1:0] peek_data,
  output logic [4:0]       SA,
  output logic [4:0]       SB,
  output logic [4:0]       DA,
  output logic [WIDTH-1:0] D,
  output logic             W,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B
);

  typedef enum logic [1:0] {IDLE, LOAD, DUMP, DONE} state_t;

  localparam logic [5:0] MAX_COUNT = 6'(REGS);

  state_t     state;
  state_t     state_nx;
  logic [4:0] ptr;
  logic [5:0] rem;
  logic [5:0] eff_count;
  logic       load_beat;
  logic       dump_take;

  // Requests longer than the register file are clipped to one full pass.
  assign eff_count = (count > MAX_COUNT) ? MAX_COUNT : count;
  assign load_beat = (state == LOAD) && in_valid;
  assign dump_take = (state == DUMP) && out_valid && out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (eff_count == 6'd0) state_nx = DONE;
          else if (mode)         state_nx = DUMP;
          else                   state_nx = LOAD;
        end
      end
      LOAD:    if (load_beat && rem == 6'd1) state_nx = DONE;
      DUMP:    if (dump_take && rem == 6'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    W         = 1'b0;
    DA        = '0;
    D         = '0;
    SA        = ptr;
    SB        = peek_addr;
    peek_data = B;
    busy      = (state != IDLE);
    if (state == LOAD) begin
      in_ready = 1'b1;
      W        = in_valid;
      DA       = ptr;
      D        = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr       <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            ptr <= base;
            rem <= eff_count;
          end
        end
        LOAD: begin
          if (in_valid) begin
            ptr <= ptr + 5'd1;
            rem <= rem - 6'd1;
          end
        end
        DUMP: begin
          // rem counts words not yet accepted; the priming read on entry
          // fills the output register without consuming one.
          if (!out_valid) begin
            out_data  <= A;
            out_valid <= 1'b1;
            ptr       <= ptr + 5'd1;
          end else if (out_ready) begin
            if (rem == 6'd1) begin
              out_valid <= 1'b0;
            end else begin
              out_data <= A;
              ptr      <= ptr + 5'd1;
              rem      <= rem - 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// tb_regfile_port_sequencer
//   Self-checking bench: a behavioural register file is attached to the
//   DUT ports; per-cycle valid/ready/data patterns are generated up front and
//   an independent model predicts beat cycles, addresses, data and done time.
module tb_regfile_port_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  base = '0;
  logic [5:0]  count = '0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [4:0]  peek_addr = '0;
  logic [63:0] peek_data;
  logic [4:0]  SA, SB, DA;
  logic [63:0] D;
  logic        W;
  logic [63:0] A, B;

  always #5 clock = ~clock;

  logic [63:0] rf [32];
  always @(posedge clock) if (W) rf[DA] <= D;
  assign A = rf[SA];
  assign B = rf[SB];

  regfile_port_sequencer #(.REGS(32), .WIDTH(64)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .base(base),
    .count(count), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .peek_addr(peek_addr), .peek_data(peek_data),
    .SA(SA), .SB(SB), .DA(DA), .D(D), .W(W), .A(A), .B(B)
  );

  int total = 0;
  int bad = 0;

  logic [63:0] exp_rf [32];
  logic        vld_pat [400];
  logic        rdy_pat [400];
  logic [63:0] dat_pat [400];

  int          obs_cyc [$];
  logic [4:0]  obs_addr [$];
  logic [63:0] obs_data [$];
  logic [63:0] obs_peek [$];
  int          obs_done, obs_first, obs_hold, obs_other;
  int          inject_cyc = -1;
  logic [63:0] peek_got [32];

  int          exp_cyc [$];
  logic [4:0]  exp_addr [$];
  logic [63:0] exp_data [$];
  int          exp_done, exp_first;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input int vld_pct, input int rdy_pct);
    for (int c = 0; c < 400; c++) begin
      vld_pat[c] = ($urandom_range(99) < vld_pct);
      rdy_pat[c] = ($urandom_range(99) < rdy_pct);
      dat_pat[c] = {$urandom, $urandom};
    end
  endtask

  // Issues one transfer and records what the DUT does each cycle.
  task automatic run_xfer(input logic m, input int b, input int c, input int pk);
    logic        prev_stall;
    logic [63:0] prev_data;
    obs_cyc.delete(); obs_addr.delete(); obs_data.delete(); obs_peek.delete();
    obs_done = -1; obs_first = -1; obs_hold = 0; obs_other = 0;
    prev_stall = 1'b0; prev_data = '0;
    start = 1'b1; mode = m; base = 5'(b); count = 6'(c);
    in_valid = 1'b0; out_ready = 1'b0; peek_addr = 5'(pk);
    step();
    start = 1'b0; base = 5'($urandom); count = 6'($urandom);
    for (int cyc = 1; cyc < 400; cyc++) begin
      in_valid  = vld_pat[cyc];
      in_data   = dat_pat[cyc];
      out_ready = rdy_pat[cyc];
      if (cyc == inject_cyc) begin
        start = 1'b1; mode = ~m; base = '0; count = 6'd5;
      end
      #1;
      obs_peek.push_back(peek_data);
      if (done) begin
        obs_done = cyc;
        start = 1'b0;
        step();
        break;
      end
      if (!m) begin
        if (W) begin
          obs_cyc.push_back(cyc); obs_addr.push_back(DA); obs_data.push_back(D);
        end
        if (out_valid) obs_other++;
      end else begin
        if (out_valid && obs_first < 0) obs_first = cyc;
        if (prev_stall && (!out_valid || out_data !== prev_data)) obs_hold++;
        if (out_valid && out_ready) begin
          obs_cyc.push_back(cyc); obs_data.push_back(out_data);
        end
        if (W) obs_other++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      step();
      start = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0; inject_cyc = -1;
  endtask

  task automatic peek_all();
    for (int i = 0; i < 32; i++) begin
      peek_addr = 5'(i);
      #1;
      peek_got[i] = peek_data;
    end
    step();
  endtask

  function automatic int eff(input int c);
    return (c > 32) ? 32 : c;
  endfunction

  // Load: beats are the first eff(c) cycles (from cycle 1) with valid high,
  // beat n lands at (b+n) mod 32; done follows the last beat.
  function automatic void model_load(input int b, input int c);
    int e, n, last;
    exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
    e = eff(c); n = 0; last = 0;
    for (int k = 1; k < 400 && n < e; k++) begin
      if (vld_pat[k]) begin
        exp_cyc.push_back(k);
        exp_addr.push_back(5'((b + n) % 32));
        exp_data.push_back(dat_pat[k]);
        exp_rf[(b + n) % 32] = dat_pat[k];
        n++; last = k;
      end
    end
    exp_done = (e == 0) ? 1 : last + 1;
  endfunction

  // Dump: word 0 shows up in cycle 2, each word is taken on the first ready
  // cycle once shown, the next word shows up the cycle after.
  function automatic void model_dump(input int b, input int c);
    int e, v, h;
    exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
    e = eff(c); v = 2;
    for (int i = 0; i < e; i++) begin
      h = v;
      while (h < 399 && !rdy_pat[h]) h++;
      exp_cyc.push_back(h);
      exp_data.push_back(exp_rf[(b + i) % 32]);
      v = h + 1;
    end
    exp_done  = (e == 0) ? 1 : v;
    exp_first = (e == 0) ? -1 : 2;
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; start = 1'b0;
    step(); step();
    total++; if (busy !== 1'b0 || in_ready !== 1'b0 || W !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: busy=%b in_ready=%b W=%b want 0 0 0", busy, in_ready, W);
    end
    total++; if (out_valid !== 1'b0 || done !== 1'b0 || out_data !== 64'd0) begin
      bad++; $display("FAIL reset_out: out_valid=%b done=%b out_data=%h want 0 0 0", out_valid, done, out_data);
    end
    total++; if (DA !== 5'd0 || D !== 64'd0 || SA !== 5'd0) begin
      bad++; $display("FAIL reset_addr: DA=%0d D=%h SA=%0d want 0 0 0", DA, D, SA);
    end
    reset = 1'b1; in_valid = 1'b0;
    step();
  endtask

  task automatic test_load_full();
    for (int c = 0; c < 400; c++) begin
      vld_pat[c] = 1'b1; dat_pat[c] = 64'hA5A5_0000_0000_0000 + 64'(c - 1);
    end
    run_xfer(1'b0, 0, 32, 0);
    model_load(0, 32);
    total++; if (obs_done != 33) begin
      bad++; $display("FAIL load_full_done: cycle %0d want 33", obs_done);
    end
    total++; if (obs_cyc.size() != 32 || obs_other != 0) begin
      bad++; $display("FAIL load_full_beats: beats=%0d out_valid=%0d want 32 0", obs_cyc.size(), obs_other);
    end
    peek_all();
    for (int i = 0; i < 32; i++) begin
      total++; if (peek_got[i] !== 64'hA5A5_0000_0000_0000 + 64'(i)) begin
        bad++; $display("FAIL load_full_reg%0d: got %h want %h", i, peek_got[i], 64'hA5A5_0000_0000_0000 + 64'(i));
      end
    end
  endtask

  task automatic test_load_random();
    int b, c;
    for (int t = 0; t < 6; t++) begin
      fill(55, 50);
      b = $urandom_range(31); c = $urandom_range(1, 40);
      run_xfer(1'b0, b, c, 0);
      model_load(b, c);
      total++; if (obs_done != exp_done || obs_cyc.size() != exp_cyc.size()) begin
        bad++; $display("FAIL load_rand_shape b=%0d c=%0d: done=%0d beats=%0d want %0d %0d",
                        b, c, obs_done, obs_cyc.size(), exp_done, exp_cyc.size());
      end else begin
        for (int i = 0; i < exp_cyc.size(); i++) begin
          total++; if (obs_cyc[i] != exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            bad++; $display("FAIL load_rand_beat%0d: cyc=%0d DA=%0d D=%h want %0d %0d %h",
                            i, obs_cyc[i], obs_addr[i], obs_data[i], exp_cyc[i], exp_addr[i], exp_data[i]);
          end
        end
      end
    end
    peek_all();
    for (int i = 0; i < 32; i++) begin
      total++; if (peek_got[i] !== exp_rf[i]) begin
        bad++; $display("FAIL load_rand_reg%0d: got %h want %h", i, peek_got[i], exp_rf[i]);
      end
    end
  endtask

  task automatic test_dump_full();
    fill(100, 100);
    run_xfer(1'b0, 5, 4, 0);
    model_load(5, 4);
    run_xfer(1'b1, 5, 4, 0);
    model_dump(5, 4);
    total++; if (obs_first != 2 || obs_done != 6) begin
      bad++; $display("FAIL dump_full_timing: first=%0d done=%0d want 2 6", obs_first, obs_done);
    end
    total++; if (obs_cyc.size() != 4 || obs_other != 0 || obs_hold != 0) begin
      bad++; $display("FAIL dump_full_shape: words=%0d W=%0d hold=%0d want 4 0 0", obs_cyc.size(), obs_other, obs_hold);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (obs_cyc[i] != 2 + i || obs_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL dump_full_word%0d: cyc=%0d data=%h want %0d %h", i, obs_cyc[i], obs_data[i], 2 + i, exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_dump_backpressure();
    fill(0, 0);
    for (int c = 2; c < 400; c++) rdy_pat[c] = ((c - 2) % 3 == 0);
    run_xfer(1'b1, 30, 3, 0);
    model_dump(30, 3);
    total++; if (obs_hold != 0 || obs_done != exp_done) begin
      bad++; $display("FAIL dump_bp_hold: hold=%0d done=%0d want 0 %0d", obs_hold, obs_done, exp_done);
    end
    total++; if (obs_cyc.size() != 3) begin
      bad++; $display("FAIL dump_bp_count: words=%0d want 3", obs_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (obs_data[i] !== exp_rf[(30 + i) % 32] || obs_cyc[i] != exp_cyc[i]) begin
          bad++; $display("FAIL dump_bp_word%0d: cyc=%0d data=%h want %0d %h", i, obs_cyc[i], obs_data[i], exp_cyc[i], exp_rf[(30 + i) % 32]);
        end
      end
    end
  endtask

  task automatic test_dump_random();
    int b, c;
    for (int t = 0; t < 6; t++) begin
      fill(50, 50);
      b = $urandom_range(31); c = $urandom_range(1, 40);
      run_xfer(1'b1, b, c, 0);
      model_dump(b, c);
      total++; if (obs_done != exp_done || obs_cyc.size() != exp_cyc.size() || obs_hold != 0 || obs_first != exp_first) begin
        bad++; $display("FAIL dump_rand_shape b=%0d c=%0d: done=%0d words=%0d hold=%0d first=%0d want %0d %0d 0 %0d",
                        b, c, obs_done, obs_cyc.size(), obs_hold, obs_first, exp_done, exp_cyc.size(), exp_first);
      end else begin
        for (int i = 0; i < exp_cyc.size(); i++) begin
          total++; if (obs_cyc[i] != exp_cyc[i] || obs_data[i] !== exp_data[i]) begin
            bad++; $display("FAIL dump_rand_word%0d: cyc=%0d data=%h want %0d %h", i, obs_cyc[i], obs_data[i], exp_cyc[i], exp_data[i]);
          end
        end
      end
    end
  endtask

  task automatic test_edge_counts();
    fill(100, 100);
    run_xfer(1'b0, 9, 0, 0);
    total++; if (obs_done != 1 || obs_cyc.size() != 0 || obs_other != 0) begin
      bad++; $display("FAIL count0_load: done=%0d W=%0d out_valid=%0d want 1 0 0", obs_done, obs_cyc.size(), obs_other);
    end
    run_xfer(1'b1, 9, 0, 0);
    total++; if (obs_done != 1 || obs_first != -1 || obs_other != 0) begin
      bad++; $display("FAIL count0_dump: done=%0d first=%0d W=%0d want 1 -1 0", obs_done, obs_first, obs_other);
    end
    run_xfer(1'b0, 17, 40, 0);
    model_load(17, 40);
    total++; if (obs_done != 33 || obs_cyc.size() != 32) begin
      bad++; $display("FAIL count40_load: done=%0d beats=%0d want 33 32", obs_done, obs_cyc.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        total++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL count40_beat%0d: DA=%0d D=%h want %0d %h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [63:0] d;
    start = 1'b1; mode = 1'b0; base = 5'd10; count = 6'd8; in_valid = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = {$urandom, $urandom};
      in_valid = 1'b1; in_data = d;
      exp_rf[10 + k] = d;
      step();
    end
    in_valid = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1; in_valid = 1'b1; d = {$urandom, $urandom}; in_data = d;
    start = 1'b1; mode = 1'b0; base = 5'd20; count = 6'd1;
    #1;
    total++; if (busy !== 1'b0 || W !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_idle: busy=%b W=%b in_ready=%b out_valid=%b want 0 0 0 0", busy, W, in_ready, out_valid);
    end
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1 || in_ready !== 1'b1 || W !== 1'b1 || DA !== 5'd20) begin
      bad++; $display("FAIL rst_mid_restart: busy=%b in_ready=%b W=%b DA=%0d want 1 1 1 20", busy, in_ready, W, DA);
    end
    exp_rf[20] = d;
    step();
    in_valid = 1'b0;
    step();
    peek_all();
    for (int i = 0; i < 32; i++) begin
      total++; if (peek_got[i] !== exp_rf[i]) begin
        bad++; $display("FAIL rst_mid_reg%0d: got %h want %h", i, peek_got[i], exp_rf[i]);
      end
    end
  endtask

  task automatic test_start_during_dump();
    fill(100, 70);
    inject_cyc = 3;
    run_xfer(1'b1, 3, 8, 7);
    model_dump(3, 8);
    total++; if (obs_done != exp_done || obs_cyc.size() != 8 || obs_other != 0) begin
      bad++; $display("FAIL start_ignored_shape: done=%0d words=%0d W=%0d want %0d 8 0", obs_done, obs_cyc.size(), obs_other, exp_done);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++; if (obs_cyc[i] != exp_cyc[i] || obs_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL start_ignored_word%0d: cyc=%0d data=%h want %0d %h", i, obs_cyc[i], obs_data[i], exp_cyc[i], exp_data[i]);
        end
      end
    end
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL start_ignored_idle: busy=%b want 0", busy);
    end
    for (int i = 0; i < obs_peek.size(); i++) begin
      total++; if (obs_peek[i] !== exp_rf[7]) begin
        bad++; $display("FAIL peek7_cyc%0d: got %h want %h", i, obs_peek[i], exp_rf[7]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_full();
    test_load_random();
    test_dump_full();
    test_dump_backpressure();
    test_dump_random();
    test_edge_counts();
    test_reset_mid_load();
    test_start_during_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
